// File: rtl/uart_tx_fifo_pkg.sv
// Shared encodings and defaults for the FIFO-buffered UART transmitter.
package UART_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 8;
  localparam int DEFAULT_DIV_W      = 16;

  typedef enum logic [1:0] {
    LEN_5 = 2'd0,
    LEN_6 = 2'd1,
    LEN_7 = 2'd2,
    LEN_8 = 2'd3
  } len_e;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  function automatic logic [7:0] len_mask(input logic [1:0] len);
    logic [7:0] mask;
    case (len)
      LEN_5:   mask = 8'h1F;
      LEN_6:   mask = 8'h3F;
      LEN_7:   mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with combinational read data and an occupancy count.
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full     = (level_q == LEVEL_FULL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // Depth is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop_ok)      level_d = level_q + LEVEL_ONE;
    else if (pop_ok && !push_ok) level_d = level_q - LEVEL_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from a byte FIFO; frame config is captured per frame at pop time.
module uart_tx_fifo
  import UART_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int DIV_W      = DEFAULT_DIV_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_en,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_len,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  logic       fifo_full, fifo_empty, pop;
  logic [7:0] fifo_data;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_ready = !fifo_full;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] reload_q, reload_d;
  logic [1:0]       len_q, len_d;
  logic [1:0]       par_mode_q, par_mode_d;
  logic             stop2_q, stop2_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_bit_q, par_bit_d;
  logic [2:0]       bit_q, bit_d;
  logic             second_stop_q, second_stop_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic       start_ok, bit_end, load_frame;
  logic [2:0] last_bit;
  logic [7:0] masked;

  assign start_ok = cfg_en && !fifo_empty;
  assign bit_end  = (cnt_q == '0);
  assign last_bit = {1'b0, len_q} + 3'd4;

  // tx follows the current state one cycle late, so every bit keeps its full width.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    reload_d      = reload_q;
    len_d         = len_q;
    par_mode_d    = par_mode_q;
    stop2_d       = stop2_q;
    shift_d       = shift_q;
    par_bit_d     = par_bit_q;
    bit_d         = bit_q;
    second_stop_d = second_stop_q;
    done_d        = 1'b0;
    pop           = 1'b0;
    load_frame    = 1'b0;
    masked        = '0;

    if (!bit_end) cnt_d = cnt_q - DIV_W'(1);

    case (state_q)
      IDLE: load_frame = start_ok;
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = reload_q;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = reload_q;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == last_bit) begin
            state_d       = parity_enabled(par_mode_q) ? PARITY : STOP;
            second_stop_d = 1'b0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d       = STOP;
          cnt_d         = reload_q;
          second_stop_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !second_stop_q) begin
            second_stop_d = 1'b1;
            cnt_d         = reload_q;
          end else begin
            done_d     = 1'b1;
            state_d    = IDLE;
            load_frame = start_ok;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_frame) begin
      pop        = 1'b1;
      state_d    = START;
      reload_d   = (cfg_div == '0) ? '0 : cfg_div - DIV_W'(1);
      cnt_d      = reload_d;
      len_d      = cfg_len;
      par_mode_d = cfg_parity;
      stop2_d    = cfg_stop2;
      masked     = fifo_data & len_mask(cfg_len);
      shift_d    = masked;
      par_bit_d  = (^masked) ^ (cfg_parity == PAR_ODD);
    end

    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      reload_q      <= '0;
      len_q         <= '0;
      par_mode_q    <= '0;
      stop2_q       <= 1'b0;
      shift_q       <= '0;
      par_bit_q     <= 1'b0;
      bit_q         <= '0;
      second_stop_q <= 1'b0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      reload_q      <= reload_d;
      len_q         <= len_d;
      par_mode_q    <= par_mode_d;
      stop2_q       <= stop2_d;
      shift_q       <= shift_d;
      par_bit_q     <= par_bit_d;
      bit_q         <= bit_d;
      second_stop_q <= second_stop_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule
